// File: rtl/cpu_pkg.sv
// Shared CPU constants for the pipeline stages: default widths, NOP encoding, PC increment.
package cpu_pkg;
  localparam int unsigned CPU_ADDR_W  = 32;
  localparam int unsigned CPU_DATA_W  = 32;
  localparam int unsigned CPU_PC_STEP = 4;
  localparam logic [31:0] CPU_NOP     = 32'h0000_0000;
endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for an instruction response that arrived while decode was stalled.
module if_skid_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              take_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] pc4_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc4_o,
  output logic              valid_o
);
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc4_q;

  // Clear and take win over load; load only ever happens on a stalled cycle.
  always_comb begin
    valid_d = valid_q;
    if (clear_i || take_i) valid_d = 1'b0;
    else if (load_i)       valid_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i && !clear_i) begin
        instr_q <= instr_i;
        pc4_q   <= pc4_i;
      end
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch front end and IF/ID pipeline register: PC, branch redirect,
// stall/flush handling and a skid entry for responses that land during a stall.
module if_id_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       DATA_W    = CPU_DATA_W,
  parameter int unsigned       ADDR_W    = CPU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       PC_STEP   = CPU_PC_STEP,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(CPU_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              pcSrc,
  input  logic [ADDR_W-1:0] ex_mem_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic [DATA_W-1:0] if_id_instr,
  output logic              if_id_valid
);
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc4_q;
  logic              issue_kill_q;
  logic              kill_now, resp_ok;

  logic              skid_load, skid_take, skid_clear, skid_valid;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc4;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;

  assign imem_req  = ~stall & ~rst;
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign pc_plus   = pc_q + ADDR_W'(PC_STEP);

  // A response dies if a redirect or flush hit its issue cycle or its return cycle.
  assign kill_now = pcSrc | flush;
  assign resp_ok  = inflight_q & ~issue_kill_q & ~kill_now;

  always_comb begin
    pc_d = pc_q;
    if (pcSrc)       pc_d = ex_mem_pc;
    else if (!stall) pc_d = pc_plus;
  end

  assign skid_clear = kill_now;
  assign skid_take  = ~kill_now & ~stall & skid_valid;
  assign skid_load  = resp_ok & stall;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (kill_now) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!stall) begin
      if (skid_valid) begin
        valid_d = 1'b1;
        instr_d = skid_instr;
        pc4_d   = skid_pc4;
      end else if (resp_ok) begin
        valid_d = 1'b1;
        instr_d = imem_rdata;
        pc4_d   = inflight_pc4_q;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      inflight_q     <= 1'b0;
      inflight_pc4_q <= '0;
      issue_kill_q   <= 1'b0;
      valid_q        <= 1'b0;
      instr_q        <= NOP_INSTR;
      pc4_q          <= '0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= ~stall;
      issue_kill_q <= kill_now;
      if (!stall) inflight_pc4_q <= pc_plus;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
    end
  end

  if_skid_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .take_i  (skid_take),
    .clear_i (skid_clear),
    .instr_i (imem_rdata),
    .pc4_i   (inflight_pc4_q),
    .instr_o (skid_instr),
    .pc4_o   (skid_pc4),
    .valid_o (skid_valid)
  );

  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: queue-based fetch model feeds a scoreboard checked by a negedge monitor.
module tb_if_id_stage;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] RPC = '0;
  localparam logic [DW-1:0] NOP = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0, flush = 1'b0, pcSrc = 1'b0;
  logic [AW-1:0] ex_mem_pc = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr, pc_out, if_id_pc4;
  logic [DW-1:0] imem_rdata, if_id_instr;
  logic          if_id_valid;

  always #5 clk = ~clk;

  if_id_stage #(
    .DATA_W(DW), .ADDR_W(AW), .RESET_PC(RPC), .PC_STEP(4), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pcSrc(pcSrc),
    .ex_mem_pc(ex_mem_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .pc_out(pc_out), .if_id_pc4(if_id_pc4),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );

  // Synchronous instruction memory: word index as instruction, junk when not requested.
  always @(posedge clk) imem_rdata <= imem_req ? DW'(imem_addr >> 2) : 32'hDEAD_BEEF;

  typedef struct {
    logic [AW-1:0] pc4;
    logic [DW-1:0] instr;
  } fetch_t;
  typedef struct {
    logic          valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] pc4;
    logic [AW-1:0] pc;
  } exp_t;

  fetch_t fq[$];
  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  logic          m_valid;
  logic [DW-1:0] m_instr;
  logic [AW-1:0] m_pc4, m_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: fetched-but-undelivered instructions sit in fq; decode takes the oldest when not stalled.
  initial begin
    fetch_t r;
    exp_t   e;
    m_pc = RPC; m_valid = 1'b0; m_instr = NOP; m_pc4 = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pc = RPC; m_valid = 1'b0; m_instr = NOP; m_pc4 = '0;
        fq.delete();
        exp_q.delete();
      end else begin
        if (pcSrc || flush) begin
          fq.delete();
          m_valid = 1'b0;
          m_instr = NOP;
        end else if (!stall) begin
          if (fq.size() > 0) begin
            r = fq.pop_front();
            m_valid = 1'b1; m_instr = r.instr; m_pc4 = r.pc4;
          end else begin
            m_valid = 1'b0; m_instr = NOP;
          end
        end
        if (!stall && !pcSrc && !flush) begin
          r.pc4 = m_pc + 4;
          r.instr = DW'(m_pc >> 2);
          fq.push_back(r);
        end
        if (pcSrc)       m_pc = ex_mem_pc;
        else if (!stall) m_pc = m_pc + 4;
        e.valid = m_valid; e.instr = m_instr; e.pc4 = m_pc4; e.pc = m_pc;
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("imem_req", 64'(imem_req), 64'(!stall));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("if_id_valid", 64'(if_id_valid), 64'(e.valid));
          chk("if_id_instr", 64'(if_id_instr), 64'(e.instr));
          chk("pc_out", 64'(pc_out), 64'(e.pc));
          chk("imem_addr", 64'(imem_addr), 64'(e.pc));
          if (e.valid) chk("if_id_pc4", 64'(if_id_pc4), 64'(e.pc4));
        end
      end
    end
  end

  task automatic step(input logic s, input logic f, input logic b, input logic [AW-1:0] t);
    stall = s; flush = f; pcSrc = b; ex_mem_pc = t;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 8, $urandom & 32'hFFFF_FFFC);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, 64'(if_id_valid), 64'(0));
    chk({tag, "_instr"}, 64'(if_id_instr), 64'(NOP));
    chk({tag, "_pc"}, 64'(pc_out), 64'(RPC));
    chk({tag, "_req"}, 64'(imem_req), 64'(0));
  endtask

  initial begin
    @(posedge clk);
    #1;
    reset_checks("reset");
    chk("reset_pc4", 64'(if_id_pc4), 64'(0));
    rst = 1'b0;
    run(4);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
    run(3);
    step(1'b0, 1'b0, 1'b1, 32'h40);
    run(4);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    run(4);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    run(5);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run(4);
    rand_run(500);
    run(2);
    step(1'b1, 1'b0, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    reset_checks("async_rst");
    @(posedge clk);
    #1;
    stall = 1'b0;
    rst = 1'b0;
    run(4);
    rand_run(300);
    run(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Parametrised instruction-fetch front end and IF/ID pipeline register for the 5-stage MIPS pipeline.
- Holds the PC and issues requests to a synchronous instruction memory with 1-cycle read latency.
- Applies the MEM-stage branch redirect (pcSrc / ex_mem_pc).
- Presents pc_4, instruction and a valid bit to decode.
- Adds stall, flush, a one-entry skid buffer for in-flight responses, and a configurable reset vector.

Parameters:
- DATA_W, 32, instruction width.
- ADDR_W, 32, PC / memory address width.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment.
- NOP_INSTR, 0, value driven on if_id_instr when the slot is empty.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  decode cannot accept; hold PC and IF/ID.
- flush  in  1  squash IF/ID and in-flight fetch; no redirect.
- pcSrc  in  1  branch taken; redirect PC to ex_mem_pc.
- ex_mem_pc  in  ADDR_W  branch target.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_rdata  in  DATA_W  instruction; valid the cycle after imem_req.
- pc_out  out  ADDR_W  current PC (debug/visibility).
- if_id_pc4  out  ADDR_W  PC+PC_STEP of the instruction in IF/ID.
- if_id_instr  out  DATA_W  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, any time, including mid-fetch):
  - pc=RESET_PC, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc4=0.
  - In-flight flag, skid buffer and skid_valid are cleared.
  - imem_req=0 while rst is high.
- Issue:
  - imem_req = !stall & !rst; imem_addr = pc (combinational).
  - On an issue cycle, register in-flight: inflight=1, inflight_pc4=pc+PC_STEP.
- PC update priority per edge: pcSrc → ex_mem_pc; else !stall → pc+PC_STEP (wraps modulo 2^ADDR_W); else hold.
  - pcSrc redirects even while stalled.
- Response cycle (inflight=1 from previous edge): the response is killed if pcSrc or flush was asserted in the cycle it was issued, or in the response cycle itself.
  - Killed: data discarded.
  - Not killed, !stall: IF/ID <= {rdata, inflight_pc4, valid=1}.
  - Not killed, stall: skid <= {rdata, inflight_pc4}, skid_valid=1; IF/ID held.
- Stall release: first cycle with stall=0 and skid_valid=1 loads IF/ID from skid and clears skid_valid. The new request issued that cycle returns next cycle; there is never a conflict.
- Neither response nor skid, !stall: if_id_valid <= 0, if_id_instr <= NOP_INSTR (bubble).
- flush or pcSrc at an edge: if_id_valid<=0, if_id_instr<=NOP_INSTR, skid_valid<=0, regardless of stall. These take priority over stall and load.
- Latency: PC visible in cycle n → instruction valid on if_id_* in cycle n+2 (unstalled).
- Redirect penalty: 2 bubbles after the pcSrc edge before target instruction is valid.
- Steady unstalled flow is one instruction per cycle, with no bubbles.
- Internal states are implicit: EMPTY / INFLIGHT / SKID_HELD, tracked by the inflight and skid_valid flags.

Decomposition:
- Shared package cpu_pkg: ADDR_W/DATA_W defaults, NOP_INSTR, and a PC_STEP constant reused by cpu_IFID and later stages.
- One natural sub-module: if_skid_buf, a one-entry holding register {instr, pc4, valid} with load/take/clear.
- PC register, kill logic and IF/ID register stay in the top.

Test Plan:
- Reset release, RESET_PC=0, imem returns addr>>2 as instr, no stall.
  - imem_addr 0,4,8… one per cycle.
  - Cycle 2: if_id_valid=1, instr=0, pc4=4; cycle 3: instr=1, pc4=8.
- Stall for 3 cycles while a fetch of addr 8 is in flight.
  - imem_req=0 during stall; PC held at 12.
  - IF/ID holds previous; skid captures instr=2.
  - First unstalled edge: instr=2, pc4=12; next: instr=3.
- pcSrc=1, ex_mem_pc=0x40 for one cycle mid-stream.
  - Next imem_addr=0x40; 2 cycles with if_id_valid=0.
  - Then instr=0x10, pc4=0x44.
- flush during stall with skid_valid=1.
  - if_id_valid=0, skid cleared.
  - After release, first valid instr comes from current pc; the skid entry is never presented.
- pc=0xFFFFFFFC unstalled → next imem_addr=0x00000000 (wrap); if_id_pc4=0 for that instruction.
- rst asserted asynchronously mid-cycle with inflight=1 and skid_valid=1.
  - All outputs reset immediately (valid=0, instr=NOP, pc_out=RESET_PC).
  - No stale instruction appears after reset release.
